// File: rtl/alu_control_unit_if.sv
// Command and arithmetic-unit bus for alu_control_unit.
// master: command issuer plus external arithmetic unit (drives cmd_* and alu_result/alu_nzvc).
// slave : the control unit itself.
interface alu_control_unit_if;
    // Command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;

    // Arithmetic unit channel
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_result;
    logic [3:0] alu_nzvc;

    // Status
    logic [7:0] acc;
    logic [3:0] flags;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, alu_result, alu_nzvc,
        input  cmd_ready, alu_a, alu_b, alu_sel, acc, flags, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, alu_result, alu_nzvc,
        output cmd_ready, alu_a, alu_b, alu_sel, acc, flags, busy, done, err
    );
endinterface

// File: rtl/alu_control_unit.sv
// Iterating accumulator controller driving an external 8-bit arithmetic unit.
// Accepts LOAD/ADD/INC/SUB/DEC commands; ALU ops repeat cmd_count times (0 means 1),
// feeding alu_result back into the accumulator each iteration.
// Optional feature: define STICKY_OVERFLOW_EN to make the V flag accumulate (OR)
// over every iteration of a command instead of reflecting only the last one.
module alu_control_unit (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_unit_if.slave   bus
);

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned FW  = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned V_BIT = 1;

    localparam logic [OPW-1:0] OP_LOAD = 3'b000;
    localparam logic [OPW-1:0] OP_ADD  = 3'b001;
    localparam logic [OPW-1:0] OP_INC  = 3'b010;
    localparam logic [OPW-1:0] OP_SUB  = 3'b011;
    localparam logic [OPW-1:0] OP_DEC  = 3'b100;

    localparam logic [SW-1:0] SEL_ADD = 2'b00;
    localparam logic [SW-1:0] SEL_INC = 2'b01;
    localparam logic [SW-1:0] SEL_SUB = 2'b10;
    localparam logic [SW-1:0] SEL_DEC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_operand;
    logic [CW-1:0]   r_remaining;
    logic [DW-1:0]   r_acc;
    logic [FW-1:0]   r_flags;
    logic            r_err;

    state_t          w_state_nxt;
    logic [OPW-1:0]  w_op_nxt;
    logic [DW-1:0]   w_operand_nxt;
    logic [CW-1:0]   w_remaining_nxt;
    logic [DW-1:0]   w_acc_nxt;
    logic [FW-1:0]   w_flags_nxt;
    logic            w_err_nxt;
    logic [SW-1:0]   w_alu_sel;

    // State and datapath registers; reset aborts any command in flight without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_operand   <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_operand   <= w_operand_nxt;
            r_remaining <= w_remaining_nxt;
            r_acc       <= w_acc_nxt;
            r_flags     <= w_flags_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state and next-datapath logic; everything holds unless a state acts on it
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_operand_nxt   = r_operand;
        w_remaining_nxt = r_remaining;
        w_acc_nxt       = r_acc;
        w_flags_nxt     = r_flags;
        w_err_nxt       = r_err;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nxt        = bus.cmd_op;
                    w_operand_nxt   = bus.cmd_data;
                    w_remaining_nxt = (bus.cmd_count == CW'(0)) ? CW'(1) : bus.cmd_count;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            w_acc_nxt   = bus.cmd_data;
                            w_flags_nxt = {bus.cmd_data[DW-1], (bus.cmd_data == DW'(0)), 1'b0, 1'b0};
                            w_err_nxt   = 1'b0;
                            w_state_nxt = S_DONE;
                        end
                        OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
`ifdef STICKY_OVERFLOW_EN
                            // Sticky V starts each ALU command clean
                            w_flags_nxt[V_BIT] = 1'b0;
`endif
                            w_err_nxt   = 1'b0;
                            w_state_nxt = S_EXEC;
                        end
                        default: begin
                            // Illegal op: report via err in DONE, leave acc/flags alone
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end
            end

            S_EXEC: begin
                w_acc_nxt       = bus.alu_result;
                w_flags_nxt     = bus.alu_nzvc;
`ifdef STICKY_OVERFLOW_EN
                w_flags_nxt[V_BIT] = r_flags[V_BIT] | bus.alu_nzvc[V_BIT];
`endif
                w_remaining_nxt = r_remaining - CW'(1);
                if (r_remaining == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU select decoded from the latched op so cmd_* never reaches alu_*
    always_comb begin
        w_alu_sel = SEL_ADD;
        case (r_op)
            OP_ADD:  w_alu_sel = SEL_ADD;
            OP_INC:  w_alu_sel = SEL_INC;
            OP_SUB:  w_alu_sel = SEL_SUB;
            OP_DEC:  w_alu_sel = SEL_DEC;
            default: w_alu_sel = SEL_ADD;
        endcase
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_EXEC);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;
    assign bus.acc       = r_acc;
    assign bus.flags     = r_flags;
    assign bus.alu_a     = r_acc;
    assign bus.alu_b     = r_operand;
    assign bus.alu_sel   = w_alu_sel;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a golden 8-bit arithmetic unit model
// closing the alu_* loop.
module tb_alu_control_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    int   n_done;

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden arithmetic unit: C is carry-out for ADD/INC and borrow for SUB/DEC
    logic [7:0] m_a, m_b, m_r;
    logic [8:0] m_w;
    logic       m_v, m_c;
    always_comb begin
        m_a = bus.alu_a;
        m_b = bus.alu_b;
        m_w = 9'h000;
        m_r = 8'h00;
        m_v = 1'b0;
        m_c = 1'b0;
        case (bus.alu_sel)
            2'b00: begin
                m_w = {1'b0, m_a} + {1'b0, m_b};
                m_r = m_w[7:0];
                m_c = m_w[8];
                m_v = (m_a[7] == m_b[7]) && (m_r[7] != m_a[7]);
            end
            2'b01: begin
                m_r = m_a + 8'h01;
                m_c = (m_a == 8'hFF);
                m_v = (m_a == 8'h7F);
            end
            2'b10: begin
                m_r = m_a - m_b;
                m_c = (m_a < m_b);
                m_v = (m_a[7] != m_b[7]) && (m_r[7] != m_a[7]);
            end
            default: begin
                m_r = m_a - 8'h01;
                m_c = (m_a == 8'h00);
                m_v = (m_a == 8'h80);
            end
        endcase
        bus.alu_result = m_r;
        bus.alu_nzvc   = {m_r[7], (m_r == 8'h00), m_v, m_c};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for one accepting edge; returns at the following negedge
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [3:0] cnt);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_count = cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_vec         = 0;
        n_fail        = 0;
        n_done        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.cmd_count = 4'h0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_acc",   32'(bus.acc),       32'h00);
        chk("rst_flags", 32'(bus.flags),     32'h0);
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_err",   32'(bus.err),       32'h0);
        chk("rst_alub",  32'(bus.alu_b),     32'h00);
        rst_n = 1'b1;

        // LOAD 0x7F
        issue(3'b000, 8'h7F, 4'h0);
        chk("load_done",  32'(bus.done),      32'h1);
        chk("load_acc",   32'(bus.acc),       32'h7F);
        chk("load_flags", 32'(bus.flags),     32'h0);
        chk("load_err",   32'(bus.err),       32'h0);
        chk("load_ready", 32'(bus.cmd_ready), 32'h0);

        // ADD 0x01 count 0 -> one iteration
        issue(3'b001, 8'h01, 4'h0);
        chk("add_busy",  32'(bus.busy),    32'h1);
        chk("add_acc0",  32'(bus.acc),     32'h7F);
        chk("add_flg0",  32'(bus.flags),   32'h0);
        chk("add_sel",   32'(bus.alu_sel), 32'h0);
        chk("add_alua",  32'(bus.alu_a),   32'h7F);
        chk("add_alub",  32'(bus.alu_b),   32'h01);
        step();
        chk("add_busy1", 32'(bus.busy),    32'h0);
        chk("add_done",  32'(bus.done),    32'h1);
        chk("add_acc",   32'(bus.acc),     32'h80);
        chk("add_flags", 32'(bus.flags),   32'hA);

        // LOAD 0xFE, INC count 3 with wraparound
        issue(3'b000, 8'hFE, 4'h0);
        chk("ldfe_flags", 32'(bus.flags), 32'h8);
        issue(3'b010, 8'h00, 4'h3);
        chk("inc_busy1", 32'(bus.busy),    32'h1);
        chk("inc_sel",   32'(bus.alu_sel), 32'h1);
        chk("inc_acc0",  32'(bus.acc),     32'hFE);
        step();
        chk("inc_busy2", 32'(bus.busy),    32'h1);
        chk("inc_acc1",  32'(bus.acc),     32'hFF);
        step();
        chk("inc_busy3", 32'(bus.busy),    32'h1);
        chk("inc_acc2",  32'(bus.acc),     32'h00);
        chk("inc_flg2",  32'(bus.flags),   32'h5);
        step();
        chk("inc_busy4", 32'(bus.busy),    32'h0);
        chk("inc_done",  32'(bus.done),    32'h1);
        chk("inc_acc3",  32'(bus.acc),     32'h01);
        chk("inc_nz",    32'(bus.flags[3:2]), 32'h0);
        step();
        chk("inc_done2", 32'(bus.done),    32'h0);
        chk("inc_ready", 32'(bus.cmd_ready), 32'h1);

        // Illegal op with acc = 0x12
        issue(3'b000, 8'h12, 4'h0);
        issue(3'b111, 8'h55, 4'h0);
        chk("ill_done",  32'(bus.done),  32'h1);
        chk("ill_err",   32'(bus.err),   32'h1);
        chk("ill_acc",   32'(bus.acc),   32'h12);
        chk("ill_flags", 32'(bus.flags), 32'h0);
        chk("ill_busy",  32'(bus.busy),  32'h0);
        step();
        chk("ill_done2", 32'(bus.done),      32'h0);
        chk("ill_err2",  32'(bus.err),       32'h0);
        chk("ill_ready", 32'(bus.cmd_ready), 32'h1);

        // cmd_valid held during EXEC must be ignored
        issue(3'b001, 8'h01, 4'h3);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'hAA;
        chk("hold_ready", 32'(bus.cmd_ready), 32'h0);
        chk("hold_busy",  32'(bus.busy),      32'h1);
        step();
        step();
        step();
        bus.cmd_valid = 1'b0;
        chk("hold_done", 32'(bus.done), 32'h1);
        chk("hold_acc",  32'(bus.acc),  32'h15);
        chk("hold_err",  32'(bus.err),  32'h0);
        chk("hold_alub", 32'(bus.alu_b), 32'h01);
        step();
        chk("hold_idle", 32'(bus.done), 32'h0);
        chk("hold_acc2", 32'(bus.acc),  32'h15);

        // LOAD 0x00 then DEC -> 0xFF with borrow
        issue(3'b000, 8'h00, 4'h0);
        chk("ld0_flags", 32'(bus.flags), 32'h4);
        issue(3'b100, 8'h00, 4'h1);
        chk("dec_sel",   32'(bus.alu_sel), 32'h3);
        step();
        chk("dec_done",  32'(bus.done),  32'h1);
        chk("dec_acc",   32'(bus.acc),   32'hFF);
        chk("dec_flags", 32'(bus.flags), 32'h9);

        // Reset during the 2nd cycle of SUB count 5
        issue(3'b011, 8'h03, 4'h5);
        chk("sub_sel",  32'(bus.alu_sel), 32'h2);
        chk("sub_busy", 32'(bus.busy),    32'h1);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_acc",   32'(bus.acc),       32'h00);
        chk("arst_flags", 32'(bus.flags),     32'h0);
        chk("arst_ready", 32'(bus.cmd_ready), 32'h1);
        chk("arst_busy",  32'(bus.busy),      32'h0);
        chk("arst_done",  32'(bus.done),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) n_done++;
            @(negedge clk);
        end
        chk("arst_nodone", 32'(n_done), 32'h0);
        chk("arst_ready2", 32'(bus.cmd_ready), 32'h1);

        // LOAD 0x7F, ADD 0x01 count 2: overflow on first iteration only
        issue(3'b000, 8'h7F, 4'h0);
        issue(3'b001, 8'h01, 4'h2);
        step();
        chk("add2_busy", 32'(bus.busy), 32'h1);
        chk("add2_flg1", 32'(bus.flags), 32'hA);
        step();
        chk("add2_done", 32'(bus.done), 32'h1);
        chk("add2_acc",  32'(bus.acc),  32'h81);
`ifdef STICKY_OVERFLOW_EN
        chk("add2_flags", 32'(bus.flags), 32'hA);
`else
        chk("add2_flags", 32'(bus.flags), 32'h8);
`endif
        step();
        chk("add2_idle", 32'(bus.cmd_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
